// File: rtl/bram_sd_pkg.sv
// Shared definitions for the backup-RAM SD sequencer: FSM states, HuBM header words, sector geometry.
package bram_sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_XFER   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FORMAT = 3'd4
    } state_t;

    localparam int SECTOR_WORDS = 256;

    localparam logic [15:0] HUBM_HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

    // A freshly formatted buffer carries the header in words 0..3 and zeros elsewhere.
    function automatic logic [15:0] fmt_word(input logic in_hdr, input logic [1:0] idx);
        return in_hdr ? HUBM_HDR[idx] : 16'h0000;
    endfunction

endpackage

// File: rtl/bram_fmt_gen.sv
// Format pattern generator: sweeps every buffer word once, one per cycle, after a start pulse.
module bram_fmt_gen
    import bram_sd_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          last,
    output logic [AW-1:0] addr,
    output logic [15:0]   data
);

    logic active;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            active <= 1'b0;
            addr   <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            addr   <= '0;
        end else if (active) begin
            if (&addr) active <= 1'b0;
            addr <= addr + 1'b1;
        end
    end

    assign busy = active;
    assign last = active && (&addr);
    assign data = fmt_word(addr[AW-1:2] == '0, addr[1:0]);

endmodule

// File: rtl/bram_sd_sync.sv
// Multi-slot backup-RAM save/load/format sequencer between the battery-RAM buffer (port B) and hps_io.
// Optional BRAM_AUTOSAVE_EN adds an idle-timeout autosave of the current slot.
module bram_sd_sync
    import bram_sd_pkg::*;
#(
    parameter int SEC_W    = 4,
    parameter int SLOT_W   = 2,
    parameter int AS_TICKS = 2**24
) (
    input  logic                                clk_sys,
    input  logic                                reset_n,
    input  logic                                download,
    input  logic                                img_mounted,
    input  logic                                img_readonly,
    input  logic [63:0]                         img_size,
    input  logic                                load_req,
    input  logic                                save_req,
    input  logic                                format_req,
    input  logic [SLOT_W-1:0]                   slot,
    input  logic                                core_wr,
    output logic [31:0]                         sd_lba,
    output logic                                sd_rd,
    output logic                                sd_wr,
    input  logic                                sd_ack,
    input  logic [7:0]                          sd_buff_addr,
    input  logic [15:0]                         sd_buff_dout,
    input  logic                                sd_buff_wr,
    output logic [SEC_W+$clog2(SECTOR_WORDS)-1:0] ramb_addr,
    output logic [15:0]                         ramb_wdata,
    output logic                                ramb_we,
    output logic                                ena,
    output logic                                busy,
    output logic                                core_hold,
    output logic                                dirty,
    output logic                                done
);

    localparam int AW = SEC_W + $clog2(SECTOR_WORDS);

    state_t           state;
    logic [SEC_W-1:0] sec_idx;
    logic             op_load;

    logic download_p1, load_p1, save_p1, format_p1, ack_p1;
    logic dl_rise, load_rise, save_rise, fmt_rise, ack_rise, ack_fall;

    logic start_fmt, start_load, start_save;
    logic as_fire;
    logic dirty_arm;

    logic          fmt_busy, fmt_last;
    logic [AW-1:0] fmt_addr;
    logic [15:0]   fmt_data;

    assign dl_rise   = download   && !download_p1;
    assign load_rise = load_req   && !load_p1;
    assign save_rise = save_req   && !save_p1;
    assign fmt_rise  = format_req && !format_p1;
    assign ack_rise  = sd_ack     && !ack_p1;
    assign ack_fall  = !sd_ack    && ack_p1;

    // Core writes are ignored while the core is held for a load or format.
    assign dirty_arm = (state != ST_FORMAT) &&
                       !(op_load && (state inside {ST_REQ, ST_XFER, ST_NEXT}));

`ifdef BRAM_AUTOSAVE_EN
    localparam int AS_W = $clog2(AS_TICKS) + 1;

    logic [AS_W-1:0] as_cnt;
    logic            as_run;

    assign as_run  = (state == ST_IDLE) && ena && dirty;
    assign as_fire = as_run && !core_wr && (as_cnt == AS_W'(AS_TICKS - 1));

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            as_cnt <= '0;
        end else if (!as_run || core_wr || as_fire) begin
            as_cnt <= '0;
        end else begin
            as_cnt <= as_cnt + 1'b1;
        end
    end
`else
    // Without the idle counter the timeout can never expire.
    assign as_fire = (AS_TICKS < 0);
`endif

    // Request arbitration: format beats load beats save; autosave ranks with save.
    always_comb begin
        start_fmt  = 1'b0;
        start_load = 1'b0;
        start_save = 1'b0;
        if (state == ST_IDLE && !dl_rise) begin
            if (fmt_rise)                         start_fmt  = 1'b1;
            else if (ena && load_rise)            start_load = 1'b1;
            else if (ena && (save_rise || as_fire)) start_save = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sec_idx     <= '0;
            op_load     <= 1'b0;
            sd_lba      <= 32'd0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            ena         <= 1'b0;
            busy        <= 1'b0;
            core_hold   <= 1'b0;
            dirty       <= 1'b0;
            done        <= 1'b0;
            download_p1 <= 1'b0;
            load_p1     <= 1'b0;
            save_p1     <= 1'b0;
            format_p1   <= 1'b0;
            ack_p1      <= 1'b0;
        end else begin
            download_p1 <= download;
            load_p1     <= load_req;
            save_p1     <= save_req;
            format_p1   <= format_req;
            ack_p1      <= sd_ack;
            done        <= 1'b0;

            if (dl_rise)
                ena <= 1'b0;
            else if (download && img_mounted && img_size != 64'd0 && !img_readonly)
                ena <= 1'b1;

            if (dl_rise && state != ST_IDLE) begin
                state     <= ST_IDLE;
                sd_rd     <= 1'b0;
                sd_wr     <= 1'b0;
                busy      <= 1'b0;
                core_hold <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_fmt) begin
                            state     <= ST_FORMAT;
                            busy      <= 1'b1;
                            core_hold <= 1'b1;
                        end else if (start_load || start_save) begin
                            state     <= ST_REQ;
                            op_load   <= start_load;
                            sec_idx   <= '0;
                            sd_lba    <= 32'({slot, {SEC_W{1'b0}}});
                            sd_rd     <= start_load;
                            sd_wr     <= !start_load;
                            busy      <= 1'b1;
                            core_hold <= start_load;
                            if (start_save) dirty <= 1'b0;
                        end
                    end
                    ST_REQ: begin
                        if (ack_rise) begin
                            sd_rd <= 1'b0;
                            sd_wr <= 1'b0;
                            state <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (ack_fall) state <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (&sec_idx) begin
                            state     <= ST_IDLE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            if (op_load) dirty <= 1'b0;
                        end else begin
                            sec_idx <= sec_idx + 1'b1;
                            sd_lba  <= sd_lba + 32'd1;
                            sd_rd   <= op_load;
                            sd_wr   <= !op_load;
                            state   <= ST_REQ;
                        end
                    end
                    ST_FORMAT: begin
                        if (fmt_last) begin
                            state     <= ST_IDLE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            dirty     <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            // A core write lands last so it re-marks the buffer even at a save start.
            if (core_wr && dirty_arm) dirty <= 1'b1;
        end
    end

    // Port B: format pattern, SD load data, or a read-only address during save.
    always_comb begin
        ramb_addr  = '0;
        ramb_wdata = 16'h0000;
        ramb_we    = 1'b0;
        if (state == ST_FORMAT) begin
            ramb_addr  = fmt_addr;
            ramb_wdata = fmt_data;
            ramb_we    = fmt_busy;
        end else if (state == ST_XFER) begin
            ramb_addr  = {sec_idx, sd_buff_addr};
            ramb_wdata = sd_buff_dout;
            ramb_we    = op_load && sd_buff_wr && sd_ack;
        end
    end

    bram_fmt_gen #(
        .AW (AW)
    ) u_fmt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (start_fmt),
        .abort   (dl_rise),
        .busy    (fmt_busy),
        .last    (fmt_last),
        .addr    (fmt_addr),
        .data    (fmt_data)
    );

endmodule

// File: tb/tb_bram_sd_sync.sv
// Randomised bench for bram_sd_sync: emulates hps_io, the buffer RAM and the core, against a protocol-level model.
module tb_bram_sd_sync;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        download, img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        load_req, save_req, format_req;
    logic [1:0]  slot;
    logic        core_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [11:0] ramb_addr;
    logic [15:0] ramb_wdata;
    logic        ramb_we;
    logic        ena, busy, core_hold, dirty, done;

    always #5 clk_sys = ~clk_sys;

    bram_sd_sync dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .download     (download),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .load_req     (load_req),
        .save_req     (save_req),
        .format_req   (format_req),
        .slot         (slot),
        .core_wr      (core_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .ramb_addr    (ramb_addr),
        .ramb_wdata   (ramb_wdata),
        .ramb_we      (ramb_we),
        .ena          (ena),
        .busy         (busy),
        .core_hold    (core_hold),
        .dirty        (dirty),
        .done         (done)
    );

    // SD card image per slot, the buffer contents the model expects, and the buffer RAM itself.
    logic [15:0] img [4][4096];
    logic [15:0] exp_buf [4096];
    logic [15:0] mem [4096];
    logic [11:0] core_a;
    logic [15:0] core_d;
    int          we_cnt = 0;

    always @(posedge clk_sys) begin
        if (ramb_we) begin
            mem[ramb_addr] <= ramb_wdata;
            we_cnt         <= we_cnt + 1;
        end
        if (core_wr) mem[core_a] <= core_d;
    end

    // Expected DUT outputs after the next rising edge.
    logic        m_busy = 0, m_hold = 0, m_dirty = 0, m_ena = 0, m_done = 0, m_rd = 0, m_wr = 0;
    logic [31:0] m_lba = 0;
    logic        mon_en = 0;
    int          n_cmp = 0, n_bad = 0;
    int          n_hold = 0, n_done = 0;
    int          x_addr_err, x_data_err;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (mon_en) begin
                chk("busy",      64'(busy),      64'(m_busy));
                chk("core_hold", 64'(core_hold), 64'(m_hold));
                chk("dirty",     64'(dirty),     64'(m_dirty));
                chk("ena",       64'(ena),       64'(m_ena));
                chk("done",      64'(done),      64'(m_done));
                chk("sd_rd",     64'(sd_rd),     64'(m_rd));
                chk("sd_wr",     64'(sd_wr),     64'(m_wr));
                chk("sd_lba",    64'(sd_lba),    64'(m_lba));
                if (core_hold === 1'b1) n_hold++;
                if (done === 1'b1) n_done++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_sys);
        m_done = 1'b0;
    endtask

    task automatic mount(input bit ro);
        tick(); download = 1; m_ena = 0;
        tick(); img_mounted = 1; img_readonly = ro; img_size = 64'd8192; m_ena = !ro;
        tick(); img_mounted = 0; download = 0;
    endtask

    task automatic core_write(input logic [11:0] a, input bit counts);
        tick();
        core_wr = 1; core_a = a; core_d = 16'($urandom);
        if (counts) begin
            exp_buf[a] = core_d;
            m_dirty    = 1;
        end
        tick(); core_wr = 0;
    endtask

    // One sector as hps_io moves it: ack up, 256 words (with random stalls), ack down.
    task automatic xfer_sector(input bit is_load, input int s, input int k);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) tick();
        tick(); sd_ack = 1; m_rd = 0; m_wr = 0;
        for (int w = 0; w < 256; w++) begin
            if ($urandom_range(0, 15) == 0) begin
                tick(); sd_buff_wr = 0;
            end
            tick();
            sd_buff_addr = 8'(w);
            if (is_load) begin
                sd_buff_dout = img[s][k*256+w];
                sd_buff_wr   = 1;
            end else begin
                #1;
                if (ramb_addr !== 12'(k*256+w)) x_addr_err++;
                if (mem[ramb_addr] !== exp_buf[k*256+w]) x_data_err++;
                img[s][k*256+w] = mem[ramb_addr];
            end
        end
        tick(); sd_buff_wr = 0; sd_ack = 0;
    endtask

    task automatic run_xfer(input bit is_load, input int s, input int abort_at,
                            input int core_at, input bit also_save, input int poke_at);
        int we0, errs;
        we0 = we_cnt; x_addr_err = 0; x_data_err = 0;
        tick();
        if (is_load) load_req = 1; else save_req = 1;
        if (also_save) save_req = 1;
        slot   = 2'(s);
        m_busy = 1; m_hold = is_load; m_rd = is_load; m_wr = !is_load;
        m_lba  = 32'(s * 16);
        if (!is_load) m_dirty = 0;
        tick(); load_req = 0; save_req = 0; slot = 2'($urandom);
        for (int k = 0; k < 16; k++) begin
            if (k == abort_at) begin
                tick(); download = 1; m_busy = 0; m_hold = 0; m_rd = 0; m_wr = 0; m_ena = 0;
                tick(); img_mounted = 1; img_readonly = 0; img_size = 64'd8192; m_ena = 1;
                tick(); img_mounted = 0; download = 0;
                return;
            end
            if (k == core_at) core_write(is_load ? 12'hFFF : 12'($urandom), !is_load);
            if (k == poke_at) begin
                tick(); save_req = 1; format_req = 1;
                tick(); save_req = 0; format_req = 0;
            end
            xfer_sector(is_load, s, k);
            tick();
            if (k == 15) begin
                m_busy = 0; m_hold = 0; m_done = 1;
                if (is_load) m_dirty = 0;
            end else begin
                m_rd = is_load; m_wr = !is_load; m_lba = m_lba + 1;
            end
        end
        tick();
        if (is_load) begin
            chk("load_we_count", 64'(we_cnt - we0), 64'd4096);
            for (int i = 0; i < 4096; i++) exp_buf[i] = img[s][i];
            errs = 0;
            for (int i = 0; i < 4096; i++) if (mem[i] !== exp_buf[i]) errs++;
            chk("load_buffer_words_wrong", 64'(errs), 64'd0);
        end else begin
            chk("save_we_count", 64'(we_cnt - we0), 64'd0);
            chk("save_addr_errors", 64'(x_addr_err), 64'd0);
            chk("save_data_errors", 64'(x_data_err), 64'd0);
        end
    endtask

    task automatic run_format(input bit poke);
        int errs;
        tick(); format_req = 1; m_busy = 1; m_hold = 1;
        for (int i = 1; i < 4096; i++) begin
            tick(); format_req = 0;
            core_wr = poke && (i == 1);
            core_a  = 12'hFFF;
            core_d  = 16'hBEEF;
        end
        tick(); m_busy = 0; m_hold = 0; m_done = 1; m_dirty = 1;
        tick();
        for (int i = 0; i < 4096; i++) exp_buf[i] = 16'h0000;
        exp_buf[0] = 16'h5548; exp_buf[1] = 16'h4D42; exp_buf[2] = 16'h8800; exp_buf[3] = 16'h8010;
        errs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== exp_buf[i]) errs++;
        chk("format_buffer_words_wrong", 64'(errs), 64'd0);
    endtask

    initial begin
        int d0, h0;
        reset_n = 0; download = 0; img_mounted = 0; img_readonly = 0; img_size = 0;
        load_req = 0; save_req = 0; format_req = 0; slot = 0; core_wr = 0;
        core_a = 0; core_d = 0; sd_ack = 0; sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 4096; i++) img[s][i] = 16'($urandom);

        repeat (3) tick();
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_core_hold", 64'(core_hold), 64'd0);
        chk("rst_dirty",     64'(dirty),     64'd0);
        chk("rst_ena",       64'(ena),       64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_sd_rd_wr",  64'({sd_rd, sd_wr}), 64'd0);
        chk("rst_sd_lba",    64'(sd_lba),    64'd0);
        chk("rst_ramb_we",   64'(ramb_we),   64'd0);
        mon_en  = 1;
        reset_n = 1;

        mount(0);
        tick();
        chk("mount_rw_ena", 64'(ena), 64'd1);

        // Load slot 2 after dirtying the buffer; the load must clear dirty.
        core_write(12'($urandom), 1);
        d0 = n_done;
        run_xfer(1, 2, -1, 0, 0, -1);
        chk("load2_final_lba", 64'(sd_lba), 64'h2F);
        chk("load2_done_pulses", 64'(n_done - d0), 64'd1);
        chk("load2_dirty", 64'(dirty), 64'd0);

        // Format: 4096 held cycles, header words, dirty set.
        h0 = n_hold; d0 = n_done;
        run_format(1);
        chk("fmt_hold_cycles", 64'(n_hold - h0), 64'd4096);
        chk("fmt_done_pulses", 64'(n_done - d0), 64'd1);
        chk("fmt_word0", 64'(mem[0]), 64'h5548);
        chk("fmt_word1", 64'(mem[1]), 64'h4D42);
        chk("fmt_word2", 64'(mem[2]), 64'h8800);
        chk("fmt_word3", 64'(mem[3]), 64'h8010);
        chk("fmt_word4", 64'(mem[4]), 64'h0000);
        chk("fmt_dirty", 64'(dirty), 64'd1);

        // Modify, save to slot 1 with a core write mid-save, then load it back.
        repeat (3) core_write(12'($urandom), 1);
        run_xfer(0, 1, -1, 7, 0, -1);
        chk("save_rewrite_dirty", 64'(dirty), 64'd1);
        run_xfer(1, 1, -1, -1, 0, -1);
        chk("reload1_word0", 64'(mem[0]), 64'h5548);

        // Read-only image: saves ignored.
        mount(1);
        tick(); save_req = 1;
        tick(); save_req = 0;
        repeat (4) tick();
        chk("ro_ena", 64'(ena), 64'd0);
        chk("ro_busy", 64'(busy), 64'd0);
        mount(0);

        // Save aborted by a new ROM download at sector 5.
        d0 = n_done;
        run_xfer(0, 3, 5, -1, 0, -1);
        repeat (4) tick();
        chk("abort_done_pulses", 64'(n_done - d0), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sd_wr", 64'(sd_wr), 64'd0);

        // Load and save on the same edge, plus save/format edges while busy.
        d0 = n_done;
        run_xfer(1, 0, -1, -1, 1, 3);
        repeat (3) tick();
        chk("ldsv_done_pulses", 64'(n_done - d0), 64'd1);
        chk("ldsv_idle", 64'(busy), 64'd0);

        for (int r = 0; r < 4; r++) begin
            case ($urandom_range(0, 3))
                0: run_xfer(1, int'($urandom_range(0, 3)), -1, -1, 0, -1);
                1: run_xfer(0, int'($urandom_range(0, 3)), -1, int'($urandom_range(0, 15)), 0, -1);
                2: run_format(0);
                default: repeat (4) core_write(12'($urandom), 1);
            endcase
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
